bus_arbiter_rr: RTL

BUS_ARBITER_RR -- requirements
Module: bus_arbiter_rr

---
 rtl/bus_arbiter_rr_pkg.sv | 26 ++
 rtl/mux_4to1.sv | 25 ++
 rtl/bus_arbiter_rr.sv | 107 ++++++++++
 3 files changed

// File: rtl/bus_arbiter_rr_pkg.sv
// rtl/bus_arbiter_rr_pkg.sv - shared types, sizes and round-robin pick helper
package bus_arbiter_rr_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_t;

  // First requesting index in the order base, base+1, base+2, base+3 (mod 4).
  // Walking the offsets from high to low lets the smallest offset win.
  function automatic logic [SEL_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                               input logic [SEL_W-1:0]   base);
    logic [SEL_W-1:0] pick;
    logic [SEL_W-1:0] idx;
    pick = base;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = base + SEL_W'(i);
      if (req[idx]) pick = idx;
    end
    return pick;
  endfunction

endpackage

// File: rtl/mux_4to1.sv
// rtl/mux_4to1.sv - 4:1 select mux for data words
module mux_4to1 #(
  parameter int W = 32
) (
  input  logic [1:0]   sel,
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic [W-1:0] d2,
  input  logic [W-1:0] d3,
  output logic [W-1:0] y
);

  // Plain index select
  always_comb begin
    y = d0;
    case (sel)
      2'd0: y = d0;
      2'd1: y = d1;
      2'd2: y = d2;
      2'd3: y = d3;
      default: y = d0;
    endcase
  end

endmodule

// File: rtl/bus_arbiter_rr.sv
// rtl/bus_arbiter_rr.sv - 4-way round-robin bus arbiter with bounded hold time
module bus_arbiter_rr
  import bus_arbiter_rr_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        req,
  input  logic [DATA_W-1:0] data_in_0,
  input  logic [DATA_W-1:0] data_in_1,
  input  logic [DATA_W-1:0] data_in_2,
  input  logic [DATA_W-1:0] data_in_3,
  output logic [3:0]        grant,
  output logic [1:0]        sel,
  output logic              busy,
  output logic [DATA_W-1:0] data_out
);

  localparam int CNT_W = $clog2(MAX_HOLD);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t             state, state_n;
  logic [SEL_W-1:0]   ptr, ptr_n;
  logic [SEL_W-1:0]   sel_n;
  logic [CNT_W-1:0]   hold_cnt, hold_cnt_n;
  logic [NUM_REQ-1:0] grant_n;
  logic [SEL_W-1:0]   base;
  logic [SEL_W-1:0]   pick;
  logic               release_now;
  logic [DATA_W-1:0]  mux_y;

  // All arbiter registers; reset drops the grant without waiting for a clock
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      ptr      <= '0;
      sel      <= '0;
      hold_cnt <= '0;
      grant    <= '0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      sel      <= sel_n;
      hold_cnt <= hold_cnt_n;
      grant    <= grant_n;
    end
  end

  // Next owner selection; a release searches from owner+1 so the owner comes last
  always_comb begin
    state_n     = state;
    ptr_n       = ptr;
    sel_n       = sel;
    hold_cnt_n  = hold_cnt;
    grant_n     = grant;
    base        = (state == OWNED) ? sel + 2'd1 : ptr;
    pick        = rr_pick(req, base);
    release_now = !req[sel] || (hold_cnt == HOLD_LAST);

    case (state)
      IDLE: begin
        grant_n    = '0;
        hold_cnt_n = '0;
        if (|req) begin
          state_n = OWNED;
          sel_n   = pick;
          grant_n = NUM_REQ'(1) << pick;
        end
      end
      OWNED: begin
        if (release_now) begin
          ptr_n      = sel + 2'd1;
          hold_cnt_n = '0;
          if (|req) begin
            sel_n   = pick;
            grant_n = NUM_REQ'(1) << pick;
          end else begin
            state_n = IDLE;
            grant_n = '0;
          end
        end else begin
          hold_cnt_n = hold_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        grant_n = '0;
      end
    endcase
  end

  assign busy = (state == OWNED);

  mux_4to1 #(.W(DATA_W)) u_mux (
    .sel (sel),
    .d0  (data_in_0),
    .d1  (data_in_1),
    .d2  (data_in_2),
    .d3  (data_in_3),
    .y   (mux_y)
  );

  assign data_out = busy ? mux_y : '0;

endmodule
